mul_radix4_sequencer: RTL

//  Multi-cycle unsigned SIZE x SIZE multiplier for the execute stage.

---
 rtl/mul_radix4_sequencer_pkg.sv | 12 +
 rtl/mul_radix4_sequencer_digit_select.sv | 25 ++
 rtl/mul_radix4_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/mul_radix4_sequencer_pkg.sv
// Shared types and defaults for the radix-4 sequential multiplier.
package mul_radix4_sequencer_pkg;

    localparam int unsigned MUL_SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage : mul_radix4_sequencer_pkg

// File: rtl/mul_radix4_sequencer_digit_select.sv
// Radix-4 partial product select: 0 / A / 2A / 3A for a 2-bit digit.
module mul_r4_digit_select #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] pp_c
);

    logic [WIDTH-1:0] a_x2;

    assign a_x2 = a << 1;

    // Pick the digit multiple; 3A is the only case needing an adder.
    always_comb begin
        pp_c = '0;
        case (sel)
            2'd0:    pp_c = '0;
            2'd1:    pp_c = a;
            2'd2:    pp_c = a_x2;
            default: pp_c = a_x2 + a;
        endcase
    end

endmodule : mul_r4_digit_select

// File: rtl/mul_radix4_sequencer.sv
// Multi-cycle unsigned SIZE x SIZE multiplier, one radix-4 digit of B per
// cycle, with early termination once the remaining B digits are zero.
module mul_radix4_sequencer
    import mul_radix4_sequencer_pkg::*;
#(
    parameter int unsigned SIZE = MUL_SIZE_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [SIZE-1:0]   iA,
    input  logic [SIZE-1:0]   iB,
    output logic              oBusy,
    output logic              oDone,
    output logic [2*SIZE-1:0] oResult
);

    localparam int unsigned PW     = 2 * SIZE;
    localparam int unsigned DIGITS = SIZE / 2;
    localparam int unsigned CW     = $clog2(DIGITS) + 1;

    mul_state_e      state;
    mul_state_e      state_next;
    logic [PW-1:0]   rA;
    logic [SIZE-1:0] rB;
    logic [PW-1:0]   rAcc;
    logic [CW-1:0]   rCnt;

    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_sum;
    logic            last_digit;

    mul_r4_digit_select #(
        .WIDTH (PW)
    ) u_digit_select (
        .sel  (rB[1:0]),
        .a    (rA),
        .pp_c (pp)
    );

    assign acc_sum    = rAcc + pp;
    // The count limit is a hard stop independent of the remaining digits.
    assign last_digit = ((rB >> 2) == '0) || (rCnt == CW'(DIGITS - 1));

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (iStart)     state_next = MUL_RUN;
            MUL_RUN:  if (last_digit) state_next = MUL_DONE;
            MUL_DONE:                 state_next = MUL_IDLE;
            default:                  state_next = MUL_IDLE;
        endcase
    end

    // Registered datapath, state and outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= MUL_IDLE;
            rA      <= '0;
            rB      <= '0;
            rAcc    <= '0;
            rCnt    <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oResult <= '0;
        end else begin
            state <= state_next;
            oBusy <= (state_next != MUL_IDLE);
            oDone <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (iStart) begin
                        rA   <= PW'(iA);
                        rB   <= iB;
                        rAcc <= '0;
                        rCnt <= '0;
                    end
                end
                MUL_RUN: begin
                    rAcc <= acc_sum;
                    rA   <= rA << 2;
                    rB   <= rB >> 2;
                    rCnt <= rCnt + CW'(1);
                    if (last_digit) begin
                        oResult <= acc_sum;
                        oDone   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : mul_radix4_sequencer
